// File: rtl/at86_iq_serializer.sv
// Serializes one 13-bit I/Q pair per frame into the AT86RF215 32-bit LVDS I/Q word,
// two bits per clock (rising-edge bit in [1]) for a downstream ODDR.
module at86_iq_serializer #(
    parameter int unsigned DATA_W     = 13,
    parameter logic [1:0]  I_SYNC     = 2'b10,
    parameter logic [1:0]  Q_SYNC     = 2'b01,
    parameter logic        CTRL_BIT   = 1'b0,
    parameter int unsigned UNDERRUN_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [DATA_W-1:0]     i_data_i,
    input  logic [DATA_W-1:0]     q_data_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic [1:0]            tx_bits_o,
    output logic                  frame_start_o,
    output logic [UNDERRUN_W-1:0] underrun_cnt_o
);

    localparam int unsigned FRAME_W   = 2 * (DATA_W + 3);
    localparam logic [3:0]  LAST_BEAT = 4'd15;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q;
    logic [3:0]            beat_q;
    logic [FRAME_W-1:0]    shift_q;
    logic [1:0]            tx_bits_q;
    logic                  frame_start_q;
    logic [UNDERRUN_W-1:0] underrun_q;

    logic                  load_d;
    logic [FRAME_W-1:0]    frame_d;

    // en_i only matters when a new frame may begin: in IDLE or on the last beat.
    always_comb begin
        load_d  = en_i && ((state_q == IDLE) || (beat_q == LAST_BEAT));
        frame_d = {I_SYNC, {DATA_W{1'b0}}, CTRL_BIT, Q_SYNC, {DATA_W{1'b0}}, CTRL_BIT};
        if (sample_valid_i) begin
            frame_d = {I_SYNC, i_data_i, CTRL_BIT, Q_SYNC, q_data_i, CTRL_BIT};
        end
    end

    // The first bit pair goes straight to the output register on load so it
    // appears the cycle after the handshake; shift_q holds the remainder.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            shift_q       <= '0;
            tx_bits_q     <= '0;
            frame_start_q <= 1'b0;
            underrun_q    <= '0;
        end else if (load_d) begin
            state_q       <= RUN;
            beat_q        <= '0;
            tx_bits_q     <= frame_d[FRAME_W-1 -: 2];
            shift_q       <= {frame_d[FRAME_W-3:0], 2'b00};
            frame_start_q <= 1'b1;
            if (!sample_valid_i && (underrun_q != '1)) begin
                underrun_q <= underrun_q + 1'b1;
            end
        end else if ((state_q == RUN) && (beat_q != LAST_BEAT)) begin
            beat_q        <= beat_q + 4'd1;
            tx_bits_q     <= shift_q[FRAME_W-1 -: 2];
            shift_q       <= {shift_q[FRAME_W-3:0], 2'b00};
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= IDLE;
            beat_q        <= '0;
            tx_bits_q     <= '0;
            frame_start_q <= 1'b0;
        end
    end

    assign sample_ready_o = load_d;
    assign tx_bits_o      = tx_bits_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_cnt_o = underrun_q;

endmodule

// File: tb/tb_at86_iq_serializer.sv
// Directed-vector bench for at86_iq_serializer: frame contents, handshake timing,
// enable/reset behaviour and underrun saturation on a narrow-counter instance.
module tb_at86_iq_serializer;

    logic        clk = 1'b0;
    logic        rst, en, vld, en4, vld4;
    logic [12:0] i_d, q_d;
    logic        ready, fs, ready4, fs4;
    logic [1:0]  tx, tx4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    at86_iq_serializer dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .i_data_i(i_d), .q_data_i(q_d),
        .sample_valid_i(vld), .sample_ready_o(ready), .tx_bits_o(tx),
        .frame_start_o(fs), .underrun_cnt_o(cnt)
    );

    at86_iq_serializer #(.UNDERRUN_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .en_i(en4), .i_data_i(i_d), .q_data_i(q_d),
        .sample_valid_i(vld4), .sample_ready_o(ready4), .tx_bits_o(tx4),
        .frame_start_o(fs4), .underrun_cnt_o(cnt4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Called at a negedge of a cycle where a load may occur (IDLE or beat 15).
    // keep_en=0 drops en_i at beat 5 and checks the return to IDLE.
    task automatic send_frame(input logic [12:0] i, input logic [12:0] q, input logic valid,
                              input logic [31:0] exp, input logic keep_en);
        en = 1'b1; vld = valid; i_d = i; q_d = q;
        #1 check("ready_load", {31'd0, ready}, 32'd1);
        if (!valid) exp_cnt++;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check($sformatf("tx_beat%0d", k), {30'd0, tx}, {30'd0, exp[31-2*k -: 2]});
            check("frame_start", {31'd0, fs}, (k == 0) ? 32'd1 : 32'd0);
            if (k == 0) begin
                check("underrun", {16'd0, cnt}, exp_cnt);
                vld = 1'b0; i_d = '0; q_d = '0;
            end
            en = keep_en || (k < 5);
            if (k < 15) #1 check("ready_mid", {31'd0, ready}, 32'd0);
        end
        if (!keep_en) begin
            #1 check("ready_end", {31'd0, ready}, 32'd0);
            @(negedge clk);
            check("idle_tx", {30'd0, tx}, 32'd0);
            check("idle_fs", {31'd0, fs}, 32'd0);
            #1 check("idle_ready", {31'd0, ready}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; en4 = 1'b0; vld4 = 1'b0;
        i_d = '0; q_d = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", {30'd0, tx}, 32'd0);
        check("rst_fs", {31'd0, fs}, 32'd0);
        check("rst_cnt", {16'd0, cnt}, 32'd0);
        check("rst_ready_held", {31'd0, ready}, 32'd0);
        rst = 1'b0;
        #1 check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_cnt4", {28'd0, cnt4}, 32'd0);

        // Single valid frame, then an underrun frame
        send_frame(13'h0FFF, 13'h1001, 1'b1, 32'h9FFE6002, 1'b0);
        send_frame(13'h0000, 13'h0000, 1'b0, 32'h80004000, 1'b0);

        // Back-to-back frames; the last one drops en_i at beat 5
        send_frame(13'h0FFF, 13'h1001, 1'b1, 32'h9FFE6002, 1'b1);
        send_frame(13'h1001, 13'h0FFF, 1'b1, 32'hA0025FFE, 1'b1);
        send_frame(13'h0123, 13'h1ABC, 1'b1, 32'h82467578, 1'b1);
        send_frame(13'h1555, 13'h0AAA, 1'b1, 32'hAAAA5554, 1'b0);

        // Reset in the middle of a frame at beat 8
        en = 1'b1; vld = 1'b1; i_d = 13'h0FFF; q_d = 13'h1001;
        #1 check("ready_abort_load", {31'd0, ready}, 32'd1);
        repeat (9) @(negedge clk);
        check("tx_beat8_pre_rst", {30'd0, tx}, 32'd1);
        rst = 1'b1; en = 1'b0; vld = 1'b0;
        @(negedge clk);
        check("abort_tx", {30'd0, tx}, 32'd0);
        check("abort_fs", {31'd0, fs}, 32'd0);
        check("abort_cnt", {16'd0, cnt}, 32'd0);
        rst = 1'b0; exp_cnt = 0;
        #1 check("abort_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("abort_idle_tx", {30'd0, tx}, 32'd0);
        send_frame(13'h1555, 13'h0AAA, 1'b1, 32'hAAAA5554, 1'b0);

        // Narrow counter saturates at 15 over 20 underrun frames
        en4 = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            check($sformatf("sat_cnt_frame%0d", j), {28'd0, cnt4}, (j < 15) ? j : 15);
            check("sat_fs", {31'd0, fs4}, 32'd1);
            repeat (15) @(negedge clk);
        end
        en4 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
